// File: rtl/gf180mcu_fd_sc_mcu7t5v0__spare_bank.sv
// Spare/ECO register bank: WIDTH flops with hold/load/shift/rotate modes,
// a saturating load-activity counter and a registered parity of the bank.
module gf180mcu_fd_sc_mcu7t5v0__spare_bank #(
  parameter int unsigned       WIDTH   = 8,
  parameter int unsigned       CNT_W   = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             PAR,
  output logic [CNT_W-1:0] CNT
);

  typedef enum logic [1:0] {
    ModeHold   = 2'b00,
    ModeLoad   = 2'b01,
    ModeShift  = 2'b10,
    ModeRotate = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q;

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    case (MODE)
      ModeHold: ;
      ModeLoad: begin
        q_d = D;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end
      ModeShift:  q_d = {q_q[WIDTH-2:0], SI};
      ModeRotate: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      // Unknown MODE must poison state rather than silently pick a branch.
      default: begin
        q_d   = 'x;
        cnt_d = 'x;
      end
    endcase
  end

  // Parity is taken from the next-state value so it never lags Q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q   <= RST_VAL;
      cnt_q <= '0;
      par_q <= ^RST_VAL;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      par_q <= ^q_d;
    end
  end

  assign Q   = q_q;
  assign CNT = cnt_q;
  assign PAR = par_q;
  assign SO  = q_q[WIDTH-1];

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__spare_bank.md
Name: gf180mcu_fd_sc_mcu7t5v0__spare_bank

Overview:
- Parametrised spare/ECO register bank for the 7-track 5V library.
- It is the functional successor to the passive fill placeholders. Instead of occupying area with no function, it provides WIDTH spare flops that can be repurposed post-layout.
- Flop modes: hold, parallel load, scan shift, rotate.
- Also provides a saturating load-activity counter and a registered parity output for ECO observability.

Parameters:
- WIDTH, 8, number of spare flops in the bank; legal range 2..32.
- CNT_W, 4, width of the load-activity counter; legal range 1..16.
- RST_VAL, 0, WIDTH-bit reset value of Q.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- MODE  input  2  operation select: 00 hold, 01 load, 10 shift, 11 rotate.
- D  input  WIDTH  parallel load data.
- SI  input  1  scan serial input.
- Q  output  WIDTH  bank register contents.
- SO  output  1  scan serial output, equal to Q[WIDTH-1].
- PAR  output  1  registered even parity of Q, equal to the XOR-reduce of Q.
- CNT  output  CNT_W  saturating count of load-mode cycles.
- VDD  inout  1  power; present only when USE_POWER_PINS is defined.
- VSS  inout  1  ground; present only when USE_POWER_PINS is defined.

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high. There is no asynchronous path.
- Reset: on a rising CLK edge with RST=1:
  - Q <= RST_VAL; CNT <= 0; PAR <= ^RST_VAL.
  - MODE, D and SI are ignored that cycle.
  - RST overrides any mode, including in the middle of a shift sequence. The next non-reset cycle starts from RST_VAL.
- Operation when RST=0, per rising edge:
  - MODE=00 hold: Q unchanged; CNT unchanged.
  - MODE=01 load: Q <= D. CNT <= CNT+1, saturating at 2^CNT_W-1; it never wraps to 0.
  - MODE=10 shift: Q <= {Q[WIDTH-2:0], SI}. SI enters at bit 0; the old Q[WIDTH-1] is lost.
  - MODE=11 rotate: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; SI is ignored.
- CNT changes only in mode 01.
- PAR is a register, not combinational. It is computed from the next-state value of Q, so PAR always matches the current Q with zero lag relative to Q, and both update on the same edge.
- SO is combinational from Q[WIDTH-1]. It therefore changes on the same edge as Q, giving single-cycle serial latency per bit.
- Latency:
  - Load: D is visible on Q one cycle after the edge.
  - Shift: a bit presented on SI appears on SO after WIDTH edges in mode 10.
- X handling: if MODE is X or Z, Q, PAR and CNT go to X. The model must not silently pick a branch.
- Power pins: functionally unused in the model. They are present only under USE_POWER_PINS, matching the library power-pin convention.
- Structure: a single always block on posedge CLK for Q, PAR and CNT, plus a continuous assign for SO. No latches. No logic beyond the registers and their next-state muxing.

Test Plan:
1. Reset and load. Assert RST for 1 cycle with MODE=01 and D=8'hFF. Expect Q=8'h00, CNT=0, PAR=0, SO=0. Then drop RST and load D=8'hA5. Expect Q=8'hA5, PAR=0, CNT=1, SO=1 on the next edge.
2. Shift. From Q=8'h00, apply mode 10 with the SI sequence 1,0,1,1,0,0,0,1 over 8 cycles. Expect Q=8'hB1 and SO=1 after the 8th edge. Expect PAR to track each intermediate Q: 1,1,0,1,1,1,1,0.
3. Rotate. Load 8'h81, then apply mode 11 for 1 cycle. Expect Q=8'h03. After 8 more rotate cycles, expect Q=8'h03 again; PAR=0 throughout. Toggling SI during rotate has no effect.
4. Counter saturation. With CNT_W=4, apply 20 consecutive load cycles. Expect CNT to reach 15 at cycle 15 and stay at 15. Hold and shift cycles do not change CNT.
5. Reset mid-operation. After 3 shift cycles, assert RST during a shift cycle. Expect Q=RST_VAL and CNT=0. With RST_VAL=8'h3C, expect PAR=0 and SO=0.
6. Hold. Load 8'h5A, then apply 10 cycles of mode 00 with D and SI randomised. Expect Q=8'h5A, PAR=0, CNT=1 for every cycle.
